// File: rtl/ultrasonido_ctrl.sv
// HC-SR04 measurement sequencer: trigger, echo timing and cm conversion,
// with timeouts for missing or over-long echoes and a re-trigger hold-off.
module ultrasonido_ctrl #(
  parameter int TRIG_CYCLES      = 500,
  parameter int ECHO_WAIT_CYCLES = 1_500_000,
  parameter int ECHO_MAX_CYCLES  = 1_250_000,
  parameter int CYCLES_PER_CM    = 2900,
  parameter int HOLDOFF_CYCLES   = 3_000_000,
  parameter int DIST_W           = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              data_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int M1 = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ?
                      TRIG_CYCLES : ECHO_WAIT_CYCLES;
  localparam int M2 = (ECHO_MAX_CYCLES > HOLDOFF_CYCLES) ?
                      ECHO_MAX_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(ECHO_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_SAT   = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              sync1_q, echo_s_q, echo_p_q;
  logic              trig_q, trig_d;
  logic              dv_q, dv_d;
  logic              to_q, to_d;
  logic              echo_rise;

  assign echo_rise = echo_s_q & ~echo_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      sync1_q  <= 1'b0;
      echo_s_q <= 1'b0;
      echo_p_q <= 1'b0;
      trig_q   <= 1'b0;
      dv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      sync1_q  <= echo;
      echo_s_q <= sync1_q;
      echo_p_q <= echo_s_q;
      trig_q   <= trig_d;
      dv_q     <= dv_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ECHO: begin
        // The rising cycle itself is the first counted echo-high cycle.
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
          sub_d   = SUB_W'(1);
          cm_d    = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!echo_s_q || cnt_q == MAX_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (cm_q != CM_SAT) cm_d = cm_q + DIST_W'(1);
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_d = (state_d == TRIG);
    dv_d   = (state_q == MEASURE) && !echo_s_q;
    to_d   = ((state_q == WAIT_ECHO) && !echo_rise &&
              (cnt_q == WAIT_LAST)) ||
             ((state_q == MEASURE) && echo_s_q &&
              (cnt_q == MAX_LAST));
    dist_d = dv_d ? cm_q : dist_q;
  end

  assign trig       = trig_q;
  assign distance   = dist_q;
  assign data_valid = dv_q;
  assign timeout    = to_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Directed bench for ultrasonido_ctrl with shortened timing parameters.
module tb_ultrasonido_ctrl;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          echo;
  logic          trig;
  logic [DW-1:0] distance;
  logic          data_valid;
  logic          timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  ultrasonido_ctrl #(
    .TRIG_CYCLES(5),
    .ECHO_WAIT_CYCLES(100),
    .ECHO_MAX_CYCLES(200),
    .CYCLES_PER_CM(10),
    .HOLDOFF_CYCLES(20),
    .DIST_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .echo(echo),
    .trig(trig),
    .distance(distance),
    .data_valid(data_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (timeout === 1'b1) to_cnt <= to_cnt + 1;
    if (data_valid === 1'b1 && timeout === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on the first negedge after trig falls (first WAIT_ECHO cycle).
  task automatic start_trig(input bit keep_en);
    int n;
    int w;
    enable = 1'b1;
    n = 0;
    while (trig !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check("trig_rise", {31'd0, trig}, 1);
    if (!keep_en) enable = 1'b0;
    w = 0;
    while (trig === 1'b1 && w < 60) begin
      tick(1);
      w++;
    end
    check("trig_width", w, 5);
  endtask

  task automatic pulse_echo(input int n);
    echo = 1'b1;
    tick(n);
    echo = 1'b0;
  endtask

  task automatic finish_meas(input int exp);
    tick(2);
    check("dv_early", {31'd0, data_valid}, 0);
    tick(1);
    check("dv_pulse", {31'd0, data_valid}, 1);
    check("distance", {23'd0, distance}, exp);
    check("to_quiet", {31'd0, timeout}, 0);
    tick(1);
    check("dv_single", {31'd0, data_valid}, 0);
    tick(18);
    check("holdoff_busy", {31'd0, busy}, 1);
    tick(1);
    check("idle_busy", {31'd0, busy}, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 600) begin
      tick(1);
      n++;
    end
    check("wait_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    int n;
    int dv0;
    int to0;
    int rise [3];
    int w_tab [3];
    int d_tab [3];
    w_tab = '{9, 10, 199};
    d_tab = '{0, 1, 19};

    rst = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    tick(3);
    check("rst_trig", {31'd0, trig}, 0);
    check("rst_dist", {23'd0, distance}, 0);
    check("rst_dv", {31'd0, data_valid}, 0);
    check("rst_to", {31'd0, timeout}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    tick(2);

    // Test 1: 57-cycle echo gives 5 cm
    start_trig(1'b0);
    check("t1_busy_wait", {31'd0, busy}, 1);
    tick(2);
    pulse_echo(57);
    check("t1_busy_meas", {31'd0, busy}, 1);
    finish_meas(5);
    check("t1_dv_count", dv_cnt, 1);

    // Test 3: no echo
    dv0 = dv_cnt;
    to0 = to_cnt;
    start_trig(1'b0);
    tick(99);
    check("t3_to_early", {31'd0, timeout}, 0);
    tick(1);
    check("t3_to_pulse", {31'd0, timeout}, 1);
    check("t3_no_dv", {31'd0, data_valid}, 0);
    check("t3_dist_kept", {23'd0, distance}, 5);
    tick(1);
    check("t3_to_single", {31'd0, timeout}, 0);
    wait_idle();
    check("t3_dv_count", dv_cnt, dv0);
    check("t3_to_count", to_cnt, to0 + 1);

    // Test 2: width boundaries
    for (int i = 0; i < 3; i++) begin
      start_trig(1'b0);
      tick(2);
      pulse_echo(w_tab[i]);
      finish_meas(d_tab[i]);
    end

    // Test 4: echo stuck high for 250 cycles
    dv0 = dv_cnt;
    to0 = to_cnt;
    start_trig(1'b0);
    echo = 1'b1;
    tick(201);
    check("t4_to_early", {31'd0, timeout}, 0);
    tick(1);
    check("t4_to_pulse", {31'd0, timeout}, 1);
    check("t4_dist_kept", {23'd0, distance}, 19);
    tick(19);
    check("t4_holdoff", {31'd0, busy}, 1);
    tick(1);
    check("t4_idle", {31'd0, busy}, 0);
    tick(28);
    echo = 1'b0;
    tick(3);
    check("t4_dv_count", dv_cnt, dv0);
    check("t4_to_count", to_cnt, to0 + 1);

    // Test 5: back-to-back runs, echo noise during hold-off
    dv0 = dv_cnt;
    to0 = to_cnt;
    enable = 1'b1;
    for (int m = 0; m < 3; m++) begin
      n = 0;
      while (trig !== 1'b1 && n < 100) begin
        tick(1);
        n++;
      end
      check("t5_rise", {31'd0, trig}, 1);
      rise[m] = cyc;
      if (m == 2) enable = 1'b0;
      n = 0;
      while (trig !== 1'b0 && n < 20) begin
        tick(1);
        n++;
      end
      tick(2);
      pulse_echo(30);
      n = 0;
      while (data_valid !== 1'b1 && n < 20) begin
        tick(1);
        n++;
      end
      check("t5_dv", {31'd0, data_valid}, 1);
      check("t5_dist", {23'd0, distance}, 3);
      tick(3);
      pulse_echo(4);
      tick(2);
      pulse_echo(3);
    end
    check("t5_gap1", rise[1] - rise[0], 61);
    check("t5_gap2", rise[2] - rise[1], 61);
    wait_idle();
    tick(5);
    check("t5_stays_idle", {31'd0, busy}, 0);
    check("t5_dv_count", dv_cnt, dv0 + 3);
    check("t5_to_count", to_cnt, to0);

    // Test 6: reset during MEASURE
    start_trig(1'b0);
    echo = 1'b1;
    tick(30);
    dv0 = dv_cnt;
    to0 = to_cnt;
    rst = 1'b1;
    #1;
    check("t6_trig", {31'd0, trig}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_dist", {23'd0, distance}, 0);
    check("t6_dv", {31'd0, data_valid}, 0);
    check("t6_to", {31'd0, timeout}, 0);
    echo = 1'b0;
    tick(2);
    rst = 1'b0;
    start_trig(1'b0);
    check("t6_no_dv", dv_cnt, dv0);
    check("t6_no_to", to_cnt, to0);
    tick(2);
    pulse_echo(20);
    finish_meas(2);

    check("exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonido_ctrl.md
Name: ultrasonido_ctrl

Overview:
Measurement sequencer for the HC-SR04 ultrasonic sensor in the Tamagotchi.
- Issues one trigger pulse per measurement.
- Times the echo pulse and converts its width to whole centimetres.
- Handles a missing echo and an over-long echo as timeouts.
- Enforces the sensor's re-trigger hold-off.
- Sits between the sensor pins and the game logic, which reads distance on data_valid.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz).
ECHO_WAIT_CYCLES, 1_500_000, maximum cycles from trigger end to echo rise (30 ms).
ECHO_MAX_CYCLES, 1_250_000, maximum echo high time before abort (25 ms, about 431 cm).
CYCLES_PER_CM, 2900, clk cycles of echo per centimetre (58 us).
HOLDOFF_CYCLES, 3_000_000, dead time after each measurement (60 ms).
DIST_W, 9, width of distance output.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
enable  in  1  level; while high, measurements repeat back-to-back
echo  in  1  raw sensor echo pin (asynchronous)
trig  out  DIST_W-independent, 1  sensor trigger pin, registered
distance  out  DIST_W  last valid distance in cm
data_valid  out  1  one-cycle pulse when distance updates
timeout  out  1  one-cycle pulse on missing or over-long echo
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high. While rst is high:
  - trig=0, distance=0, data_valid=0, timeout=0, busy=0.
  - state=IDLE; all counters=0; synchroniser flops=0.
- Echo synchroniser:
  - echo passes through 2 flops to give echo_s.
  - A rising edge is echo_s=1 with the previous echo_s=0.
  - All echo decisions use echo_s only.
- IDLE:
  - trig=0.
  - If enable=1, go to TRIG next edge with counter cleared.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES consecutive cycles, then go to WAIT_ECHO with counter cleared.
  - enable is ignored once TRIG is entered.
- WAIT_ECHO:
  - counter increments each cycle.
  - On an echo_s rising edge, go to MEASURE with cm_cnt=0 and sub_cnt=1.
  - If counter reaches ECHO_WAIT_CYCLES-1 with no rising edge: pulse timeout for 1 cycle, go to HOLDOFF.
  - An echo already high on entry (no rising edge) is not a valid start.
- MEASURE:
  - sub_cnt increments each cycle while echo_s=1.
  - When sub_cnt reaches CYCLES_PER_CM, sub_cnt resets to 0 and cm_cnt increments.
  - cm_cnt saturates at 2^DIST_W-1.
  - On the first cycle with echo_s=0: distance<=cm_cnt, data_valid=1 for one cycle, go to HOLDOFF.
  - Result: distance = floor(N/CYCLES_PER_CM), where N is the number of cycles the raw echo was sampled high.
  - data_valid rises on the 3rd rising clk edge after the first edge that samples echo low.
  - If total echo-high cycles reach ECHO_MAX_CYCLES: pulse timeout, leave distance unchanged, go to HOLDOFF.
- HOLDOFF:
  - Count HOLDOFF_CYCLES, then go to IDLE.
  - If enable is still 1, the next TRIG starts one cycle later.
  - Echo activity is ignored.
- Output exclusivity and persistence:
  - data_valid and timeout are never high in the same cycle.
  - distance holds its last valid value across timeouts.
- enable dropped mid-measurement: the measurement and hold-off complete; the FSM then stays in IDLE.
- Reset mid-operation: outputs take reset values immediately; no data_valid or timeout is emitted for the aborted cycle.

Test Plan:
All tests use TRIG_CYCLES=5, CYCLES_PER_CM=10, ECHO_WAIT_CYCLES=100, ECHO_MAX_CYCLES=200, HOLDOFF_CYCLES=20.
1. enable=1; echo high 57 cycles starting 3 cycles after trig falls -> trig high exactly 5 cycles; distance=5; single data_valid 3 edges after echo falls; busy=1 throughout until IDLE.
2. Boundary widths: echo high 9 cycles -> distance=0 with data_valid; echo high 10 cycles -> distance=1; echo high 199 cycles -> distance=19.
3. No echo after trigger -> timeout pulse 100 cycles after WAIT_ECHO entry; distance keeps previous value 5; no data_valid.
4. Echo stuck high for 250 cycles -> timeout at 200 echo-high cycles; distance unchanged; next trig no earlier than 20 hold-off cycles later.
5. enable held high over 3 measurements -> trig rising edges separated by 5 + wait/measure + 20 + 1 cycles; echo toggled during HOLDOFF produces no output.
6. rst asserted while in MEASURE, 30 cycles into echo -> trig, busy, distance, data_valid and timeout go to 0 immediately; after release with enable=1, a new 5-cycle trig is issued.
